// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_check
// Brief    : UART RX frame checker. Judges start, data, parity and stop bits
//            at one oversample edge per bit, assembles the received word,
//            pulses per-frame error flags and keeps saturating error counters.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int CNT_W      = 5,
  parameter int CHK_OFFSET = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  chk_en,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [CNT_W-1:0]      bit_cnt,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  err_clr,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ERR_CNT_W-1:0]  glitch_cnt,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

  // Bit indices as presented by the upstream edge/bit counter.
  localparam logic [CNT_W-1:0]   FIRST_DATA_IDX = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LAST_DATA_IDX  = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   PARITY_IDX     = CNT_W'(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]   STOP_IDX_NOPAR = CNT_W'(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]   STOP_IDX_PAR   = CNT_W'(DATA_WIDTH + 2);
  localparam logic [PRESC_W-1:0] OFFSET         = PRESC_W'(CHK_OFFSET);

  // The start bit is judged on the same strobe that leaves IDLE, so a
  // glitch is reported one cycle after its strobe like every other pulse.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      exp_idx;     // bit_cnt expected on the next data strobe
  logic [DATA_WIDTH-1:0] shreg;
  logic                  run_par;
  logic                  frame_bad;
  logic                  par_en_q;
  logic                  par_typ_q;

  logic                  strobe;
  logic [CNT_W-1:0]      stop_idx;
  logic [DATA_WIDTH:0]   shift_wide;
  logic [DATA_WIDTH-1:0] shift_next;

  // Evaluation edge compensates for the sampler's pipeline latency.
  assign strobe     = chk_en && (edge_cnt == (Prescale - OFFSET));
  assign stop_idx   = par_en_q ? STOP_IDX_PAR : STOP_IDX_NOPAR;
  // LSB-first: each new bit enters at the MSB and earlier bits move down.
  assign shift_wide = {sampled_bit, shreg} >> 1;
  assign shift_next = shift_wide[DATA_WIDTH-1:0];

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Frame FSM: sequences the bits, assembles the word and registers pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      exp_idx     <= '0;
      shreg       <= '0;
      run_par     <= 1'b0;
      frame_bad   <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
    end else begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      data_valid  <= 1'b0;
      if (!chk_en) begin
        // Frame abandoned upstream: drop partial state silently.
        state     <= S_IDLE;
        frame_bad <= 1'b0;
      end else if (strobe) begin
        case (state)
          S_IDLE: begin
            if (bit_cnt == '0) begin
              if (sampled_bit) begin
                strt_glitch <= 1'b1;
              end else begin
                state     <= S_DATA;
                exp_idx   <= FIRST_DATA_IDX;
                run_par   <= 1'b0;
                frame_bad <= 1'b0;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
              end
            end
          end
          S_DATA: begin
            if (bit_cnt != exp_idx) begin
              state <= S_IDLE;
            end else begin
              shreg   <= shift_next;
              run_par <= run_par ^ sampled_bit;
              exp_idx <= exp_idx + 1'b1;
              if (bit_cnt == LAST_DATA_IDX) begin
                state <= par_en_q ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            if (bit_cnt != PARITY_IDX) begin
              state <= S_IDLE;
            end else begin
              if (sampled_bit != (run_par ^ par_typ_q)) begin
                par_err   <= 1'b1;
                frame_bad <= 1'b1;
              end
              state <= S_STOP;
            end
          end
          S_STOP: begin
            state     <= S_IDLE;
            frame_bad <= 1'b0;
            if (bit_cnt == stop_idx) begin
              if (!sampled_bit) begin
                stp_err <= 1'b1;
              end else if (!frame_bad) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Saturating status counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      glitch_cnt  <= '0;
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (err_clr) begin
      glitch_cnt  <= '0;
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else begin
      if (strt_glitch) glitch_cnt  <= sat_inc(glitch_cnt);
      if (par_err)     par_err_cnt <= sat_inc(par_err_cnt);
      if (stp_err)     stp_err_cnt <= sat_inc(stp_err_cnt);
    end
  end

endmodule
`default_nettype wire
